bullet_sched: RTL and testbench

Fire controller for a pool of NUM_SLOTS player bullet engines.
- Edge-detects the player fire button and enforces a frame-based cooldown between shots.
- Tracks a magazine with an automatic reload sequence.
- Routes each accepted shot to the lowest-index idle bullet slot as a one-cycle fire pulse.
- Sits between the input/player logic and the bullet instances; feeds the HUD with ammo and reload status.

---
 rtl/bullet_pkg.sv | 16 +
 rtl/slot_pick.sv | 16 +
 rtl/bullet_sched.sv | 137 +++++++++++++
 tb/tb_bullet_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// bullet_pkg: shared types and constants for the player bullet subsystem.
package bullet_pkg;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2,
        RELOAD   = 2'd3
    } sched_state_t;

    localparam int SCREEN_W     = 640;
    localparam int BULLET_SIZE  = 4;
    localparam int BULLET_SPEED = 4;
    localparam int AMMO_W       = 4;

endpackage

// File: rtl/slot_pick.sv
// slot_pick: combinational finder for the lowest-index idle bullet slot.
// onehot is zero when every slot is busy.
module slot_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] busy,
    output logic [N-1:0] onehot,
    output logic         any_free
);

    // Adding one ripples through the trailing busy bits and lands on the
    // lowest zero; masking with ~busy isolates exactly that bit.
    assign onehot   = ~busy & (busy + N'(1));
    assign any_free = ~&busy;

endmodule

// File: rtl/bullet_sched.sv
// bullet_sched: fire controller for a pool of bullet engines. Detects fire
// button edges, enforces a frame-based cooldown, tracks a magazine with
// automatic/manual reload and routes each shot to the lowest idle slot.
// Optional build macro AUTO_FIRE_EN: a held fire button re-arms a shot each
// time the cooldown expires back into READY.
module bullet_sched
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MAG_SIZE        = 6,
    parameter int RELOAD_FRAMES   = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 fire_btn,
    input  logic                 reload_btn,
    input  logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] fire_slot,
    output logic [AMMO_W-1:0]    ammo,
    output logic                 reloading,
    output logic                 cooling,
    output logic [15:0]          shots_total
);

    sched_state_t         state, state_n;
    logic                 fire_q, reload_q;
    logic                 pending, pending_n;
    logic [7:0]           frame_cnt;
    logic [NUM_SLOTS-1:0] pick;
    logic                 any_free;

    logic fire_edge, reload_edge, ammo_empty, cool_done, rel_done;
    logic go_fire, go_reload;

    slot_pick #(.N(NUM_SLOTS)) u_pick (
        .busy     (slot_active),
        .onehot   (pick),
        .any_free (any_free)
    );

    assign fire_edge   = fire_btn & ~fire_q;
    assign reload_edge = reload_btn & ~reload_q;
    assign ammo_empty  = (ammo == '0);
    assign cool_done   = frame_tick && (frame_cnt == 8'(COOLDOWN_FRAMES - 1));
    assign rel_done    = frame_tick && (frame_cnt == 8'(RELOAD_FRAMES - 1));
    assign go_fire     = pending && !ammo_empty && any_free;
    // A fire edge in the same cycle as a manual reload edge wins: the reload
    // request is dropped so the pending shot fires on the next cycle.
    assign go_reload   = ammo_empty ||
                         (reload_edge && !fire_edge && (ammo < AMMO_W'(MAG_SIZE)));

    // Next-state and pending-flag logic.
    always_comb begin
        state_n   = state;
        pending_n = pending;
        case (state)
            READY: begin
                if (go_fire) begin
                    state_n = FIRE;
                end else if (go_reload) begin
                    state_n   = RELOAD;
                    pending_n = 1'b0;
                end else if (fire_edge) begin
                    pending_n = 1'b1;
                end else if (frame_tick) begin
                    pending_n = 1'b0;
                end
            end
            FIRE: begin
                state_n   = COOLDOWN;
                pending_n = 1'b0;
            end
            COOLDOWN: begin
                pending_n = 1'b0;
                if (cool_done) begin
                    state_n = ammo_empty ? RELOAD : READY;
`ifdef AUTO_FIRE_EN
                    if (!ammo_empty && fire_btn) pending_n = 1'b1;
`endif
                end
            end
            RELOAD: begin
                pending_n = 1'b0;
                if (rel_done) state_n = READY;
            end
            default: state_n = READY;
        endcase
    end

    // State, edge history and pending registers; history resets high so a
    // button held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= READY;
            pending  <= 1'b0;
            fire_q   <= 1'b1;
            reload_q <= 1'b1;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            fire_q   <= fire_btn;
            reload_q <= reload_btn;
        end
    end

    // Frame counter: cleared on every state change (so a tick during FIRE is
    // lost), counts ticks only while cooling or reloading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (state != state_n) begin
            frame_cnt <= '0;
        end else if (frame_tick && (state == COOLDOWN || state == RELOAD)) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Magazine and lifetime shot counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ammo        <= AMMO_W'(MAG_SIZE);
            shots_total <= '0;
        end else if (state == FIRE) begin
            ammo        <= ammo - AMMO_W'(1);
            shots_total <= shots_total + 16'd1;
        end else if (state == RELOAD && rel_done) begin
            ammo        <= AMMO_W'(MAG_SIZE);
        end
    end

    assign fire_slot = (state == FIRE) ? pick : '0;
    assign cooling   = (state == COOLDOWN);
    assign reloading = (state == RELOAD);

endmodule

// File: tb/tb_bullet_sched.sv
// tb_bullet_sched: directed scenarios plus randomized stimulus, checked every
// cycle against a frame-countdown behavioural model of the fire controller.
module tb_bullet_sched;

    localparam int NS   = 4;
    localparam int COOL = 8;
    localparam int MAG  = 6;
    localparam int REL  = 60;

    localparam int P_READY  = 0;
    localparam int P_FIRE   = 1;
    localparam int P_COOL   = 2;
    localparam int P_RELOAD = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          fire_btn = 1'b0;
    logic          reload_btn = 1'b0;
    logic [NS-1:0] slot_active = '0;
    logic [NS-1:0] fire_slot;
    logic [3:0]    ammo;
    logic          reloading, cooling;
    logic [15:0]   shots_total;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // model state
    int m_phase, m_ammo, m_shots, m_left;
    bit m_pend, m_pf, m_pr, f_edge, r_edge;
    logic [NS-1:0] exp_slot;

    bullet_sched #(
        .NUM_SLOTS(NS), .COOLDOWN_FRAMES(COOL), .MAG_SIZE(MAG), .RELOAD_FRAMES(REL)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire_btn(fire_btn),
        .reload_btn(reload_btn), .slot_active(slot_active), .fire_slot(fire_slot),
        .ammo(ammo), .reloading(reloading), .cooling(cooling), .shots_total(shots_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] lowest_free(input logic [NS-1:0] sa);
        for (int i = 0; i < NS; i++)
            if (!sa[i]) return NS'(1) << i;
        return '0;
    endfunction

    // Per-cycle compare against the model, then advance the model by one clock.
    always @(negedge clk) begin
        if (fire_slot != '0) pulses++;
        if (!reset) begin
            m_phase = P_READY; m_ammo = MAG; m_shots = 0; m_left = 0;
            m_pend = 0; m_pf = 1; m_pr = 1;
        end
        exp_slot = (m_phase == P_FIRE) ? lowest_free(slot_active) : '0;
        check("fire_slot", 32'(fire_slot), 32'(exp_slot));
        check("ammo", 32'(ammo), 32'(m_ammo));
        check("shots_total", 32'(shots_total), 32'(m_shots));
        check("cooling", 32'(cooling), 32'(m_phase == P_COOL));
        check("reloading", 32'(reloading), 32'(m_phase == P_RELOAD));
        if (reset) begin
            f_edge = fire_btn && !m_pf;
            r_edge = reload_btn && !m_pr;
            case (m_phase)
                P_READY: begin
                    if (m_pend && m_ammo > 0 && slot_active != '1) m_phase = P_FIRE;
                    else if (m_ammo == 0 || (r_edge && !f_edge && m_ammo < MAG)) begin
                        m_phase = P_RELOAD; m_left = REL; m_pend = 0;
                    end else if (f_edge) m_pend = 1;
                    else if (frame_tick) m_pend = 0;
                end
                P_FIRE: begin
                    m_ammo--; m_shots = (m_shots + 1) % 65536; m_pend = 0;
                    m_phase = P_COOL; m_left = COOL;
                end
                P_COOL: if (frame_tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_ammo == 0) begin
                            m_phase = P_RELOAD; m_left = REL;
                        end else begin
                            m_phase = P_READY;
`ifdef AUTO_FIRE_EN
                            if (fire_btn) m_pend = 1;
`endif
                        end
                    end
                end
                default: if (frame_tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ammo = MAG; m_phase = P_READY;
                    end
                end
            endcase
            m_pf = fire_btn;
            m_pr = reload_btn;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1; cyc(1);
        frame_tick = 1'b0; cyc(1);
    endtask

    task automatic shoot();
        fire_btn = 1'b1; cyc(1);
        fire_btn = 1'b0; cyc(3);
        repeat (COOL) tick();
    endtask

    int p0;

    initial begin
        // reset with the button held: no shot after release
        fire_btn = 1'b1;
        #2 reset = 1'b0;
        cyc(3); reset = 1'b1; cyc(5);
        @(negedge clk);
        check("rst_ammo", 32'(ammo), 6);
        check("rst_shots", 32'(shots_total), 0);
        check("rst_no_pulse", pulses, 0);
        fire_btn = 1'b0; cyc(2);

        // single shot into slot 2, latency and cooldown length
        slot_active = 4'b0011; cyc(1);
        fire_btn = 1'b1;
        @(negedge clk); check("lat_c0", 32'(fire_slot), 0);
        cyc(1); @(negedge clk); check("lat_c1", 32'(fire_slot), 0);
        cyc(1); @(negedge clk); check("lat_c2_pulse", 32'(fire_slot), 32'b0100);
        cyc(1); @(negedge clk); check("after_pulse", 32'(fire_slot), 0);
        check("ammo_5", 32'(ammo), 5);
        check("model_ammo_5", m_ammo, 5);
        check("cooling_on", 32'(cooling), 1);
        fire_btn = 1'b0;
        repeat (COOL - 1) tick();
        @(negedge clk); check("cooling_7", 32'(cooling), 1);
        tick();
        @(negedge clk); check("cooling_off", 32'(cooling), 0);

        // empty the magazine, automatic reload, fire ignored in reload
        slot_active = '0;
        repeat (5) shoot();
        @(negedge clk);
        check("empty_reloading", 32'(reloading), 1);
        check("empty_ammo", 32'(ammo), 0);
        check("six_pulses", pulses, 6);
        fire_btn = 1'b1; cyc(2); fire_btn = 1'b0; cyc(2);
        @(negedge clk); check("no_fire_in_reload", pulses, 6);
        repeat (REL - 1) tick();
        @(negedge clk); check("reload_59", 32'(reloading), 1);
        tick();
        @(negedge clk);
        check("reload_done", 32'(reloading), 0);
        check("reload_ammo", 32'(ammo), 6);

        // all slots busy: pending shot dropped on the next frame tick
        slot_active = '1;
        fire_btn = 1'b1; cyc(1); fire_btn = 1'b0; cyc(2);
        tick();
        slot_active = '0; cyc(4);
        @(negedge clk);
        check("busy_no_pulse", pulses, 6);
        check("busy_ammo", 32'(ammo), 6);

        // fire beats a same-cycle manual reload; later reload edge is honoured
        repeat (3) shoot();
        @(negedge clk); check("ammo_3", 32'(ammo), 3);
        fire_btn = 1'b1; reload_btn = 1'b1; cyc(3);
        @(negedge clk);
        check("prio_ammo", 32'(ammo), 2);
        check("prio_no_reload", 32'(reloading), 0);
        check("prio_cooling", 32'(cooling), 1);
        fire_btn = 1'b0; reload_btn = 1'b0;
        repeat (COOL) tick();
        cyc(1); reload_btn = 1'b1; cyc(1); reload_btn = 1'b0;
        @(negedge clk); check("manual_reload", 32'(reloading), 1);
        repeat (REL) tick();
        @(negedge clk); check("manual_ammo", 32'(ammo), 6);

        // held button for 40 frames
        p0 = pulses;
        fire_btn = 1'b1; cyc(3);
        repeat (40) begin tick(); cyc(2); end
        fire_btn = 1'b0;
        @(negedge clk);
`ifdef AUTO_FIRE_EN
        check("hold_shots", pulses - p0, 6);
        check("hold_ammo", 32'(ammo), 0);
        repeat (COOL + REL) tick();
`else
        check("hold_shots", pulses - p0, 1);
        check("hold_ammo", 32'(ammo), 5);
`endif

        // randomized traffic, with one asynchronous reset mid-run
        for (int i = 0; i < 4000; i++) begin
            frame_tick = ($urandom_range(5) == 0);
            if ($urandom_range(7) == 0) fire_btn = ~fire_btn;
            if ($urandom_range(23) == 0) reload_btn = ~reload_btn;
            if ($urandom_range(9) == 0) slot_active = NS'($urandom_range(15));
            reset = (i != 2000);
            cyc(1);
        end
        frame_tick = 1'b0; reset = 1'b1;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
